// File: rtl/usb_tx_framer_pkg.sv
// Shared constants, FSM encoding and escape helper for the FX2 EP6 IN framer.
package usb_tx_framer_pkg;

  localparam logic [15:0] HDR_WORD  = 16'hAA55;
  localparam logic [15:0] TERM_WORD = 16'hFAFA;
  localparam logic [15:0] ESC_WORD  = 16'hFAF9;
  localparam int          USBNUM_W  = 14;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CNT  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CSUM = 3'd4,
    ST_TERM = 3'd5
  } state_t;

  // Keeps the terminator value unique to the last word of a frame.
  function automatic logic [15:0] esc(input logic [15:0] x,
                                      input logic [15:0] term,
                                      input logic [15:0] sub);
    return (x == term) ? sub : x;
  endfunction

endpackage

// File: rtl/usb_tx_fifo.sv
// Single-clock FIFO with registered read data and count, sticky over/underflow.
// Read data valid the cycle after a request; writes to a full FIFO are dropped.
module usb_tx_fifo #(
  parameter int ADDR_W = 10,
  parameter int DAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_vld_i,
  input  logic [DAT_W-1:0]  wr_dat_i,
  input  logic              rd_req_i,
  output logic [DAT_W-1:0]  rd_dat_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [DAT_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DAT_W-1:0]  rd_dat_q;
  logic              ovf_q, udf_q;
  logic              full, empty, wr_ok, rd_ok;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign wr_ok = wr_vld_i && !full;
  assign rd_ok = rd_req_i && !empty;

  // No reset on the array so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rd_dat_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        rd_dat_q <= mem_q[rd_ptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + (ADDR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (ADDR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (wr_vld_i && full)  ovf_q <= 1'b1;
      if (rd_req_i && empty) udf_q <= 1'b1;
    end
  end

  assign rd_dat_o    = rd_dat_q;
  assign count_o     = cnt_q;
  assign empty_o     = empty;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: rtl/usb_tx_framer.sv
// Wraps payload samples as header/counter/payload/checksum/terminator frames into the EP6 FIFO.
// A frame starts only when the whole frame fits, so only the payload phase can stall on DatValid.
module usb_tx_framer #(
  parameter int          ADDR_W    = 10,
  parameter int          FRAME_LEN = 64,
  parameter logic [15:0] HDR_WORD  = usb_tx_framer_pkg::HDR_WORD,
  parameter logic [15:0] TERM_WORD = usb_tx_framer_pkg::TERM_WORD,
  parameter logic [15:0] ESC_WORD  = usb_tx_framer_pkg::ESC_WORD
) (
  input  logic        IFCLK,
  input  logic        RST,
  input  logic [15:0] DatIn,
  input  logic        DatValid,
  output logic        DatReady,
  input  logic        USBRreq,
  output logic [15:0] Send,
  output logic        USBEmpty,
  output logic [13:0] USBNum,
  output logic [15:0] FrameCnt,
  output logic        Overflow,
  output logic        Underflow
);

  import usb_tx_framer_pkg::*;

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PCNT_W = $clog2(FRAME_LEN + 1);
  localparam int FW     = ADDR_W + 2;

  state_t              state_q, state_d;
  logic [PCNT_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic [15:0]         csum_q, csum_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [ADDR_W:0]     fifo_cnt;
  logic [FW-1:0]       free_words;
  logic                space_ok, accept, last_pay;
  logic                wr_vld;
  logic [15:0]         wr_dat;
  logic [15:0]         pay_esc;

  assign free_words = FW'(DEPTH) - FW'(fifo_cnt);
  assign space_ok   = (free_words >= FW'(FRAME_LEN + 4));
  assign accept     = (state_q == ST_PAY) && DatValid;
  assign last_pay   = (pay_cnt_q == PCNT_W'(FRAME_LEN - 1));
  assign pay_esc    = esc(DatIn, TERM_WORD, ESC_WORD);

  always_ff @(posedge IFCLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      pay_cnt_q   <= '0;
      csum_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pay_cnt_q   <= pay_cnt_d;
      csum_q      <= csum_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (DatValid && space_ok) state_d = ST_HDR;
      ST_HDR:  state_d = ST_CNT;
      ST_CNT:  state_d = ST_PAY;
      ST_PAY:  if (accept && last_pay) state_d = ST_CSUM;
      ST_CSUM: state_d = ST_TERM;
      ST_TERM: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    DatReady = 1'b0;
    wr_vld   = 1'b0;
    wr_dat   = '0;
    case (state_q)
      ST_HDR:  begin wr_vld = 1'b1; wr_dat = HDR_WORD; end
      ST_CNT:  begin wr_vld = 1'b1; wr_dat = esc(frame_cnt_q, TERM_WORD, ESC_WORD); end
      ST_PAY:  begin DatReady = 1'b1; wr_vld = DatValid; wr_dat = pay_esc; end
      ST_CSUM: begin wr_vld = 1'b1; wr_dat = esc(csum_q, TERM_WORD, ESC_WORD); end
      ST_TERM: begin wr_vld = 1'b1; wr_dat = TERM_WORD; end
      default: ;
    endcase
  end

  always_comb begin
    pay_cnt_d   = pay_cnt_q;
    csum_d      = csum_q;
    frame_cnt_d = frame_cnt_q;
    if (state_q == ST_HDR) begin
      pay_cnt_d = '0;
      csum_d    = '0;
    end
    if (accept) begin
      pay_cnt_d = pay_cnt_q + PCNT_W'(1);
      csum_d    = csum_q + pay_esc;
    end
    if (state_q == ST_TERM) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  usb_tx_fifo #(
    .ADDR_W (ADDR_W),
    .DAT_W  (16)
  ) u_fifo (
    .clk_i       (IFCLK),
    .rst_ni      (RST),
    .wr_vld_i    (wr_vld),
    .wr_dat_i    (wr_dat),
    .rd_req_i    (USBRreq),
    .rd_dat_o    (Send),
    .count_o     (fifo_cnt),
    .empty_o     (USBEmpty),
    .overflow_o  (Overflow),
    .underflow_o (Underflow)
  );

  assign USBNum   = USBNUM_W'(fifo_cnt);
  assign FrameCnt = frame_cnt_q;

endmodule
